// File: rtl/dmem_resp.sv
// Data-memory responder: single-outstanding load/store slave with a fixed
// access latency, RV32 byte/half/word lanes and sign/zero extension.
module dmem_resp #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_op,
    input  logic        req_wen,
    input  logic        req_ren,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]  LAT  = 4'(LATENCY);
    localparam logic [32:0] SPAN = 33'(1) << (ADDR_BITS + 2);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [31:0] lat_addr, lat_wdata;
    logic [2:0]  lat_op;
    logic        lat_wen, lat_ren;
    logic [31:0] mem [2**ADDR_BITS];

    logic        accept, commit;
    logic [31:0] c_addr, c_wdata;
    logic [2:0]  c_op;
    logic        c_wen, c_ren;
    logic [31:0] offset, word, lane_wdata, rdata;
    logic [ADDR_BITS-1:0] idx;
    logic        err, do_write;
    logic [3:0]  be;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LAT == 4'd0) begin
                        commit     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        // A zero-latency commit happens on the acceptance edge, so decode the live inputs then.
        if (state == IDLE) begin
            c_addr  = req_addr;
            c_op    = req_op;
            c_wen   = req_wen;
            c_ren   = req_ren;
            c_wdata = req_wdata;
        end else begin
            c_addr  = lat_addr;
            c_op    = lat_op;
            c_wen   = lat_wen;
            c_ren   = lat_ren;
            c_wdata = lat_wdata;
        end
        offset = c_addr - BASE_ADDR;
        idx    = offset[ADDR_BITS+1:2];
        word   = mem[idx];
        sel_b  = word[{c_addr[1:0], 3'b000} +: 8];
        sel_h  = word[{c_addr[1], 4'b0000} +: 16];

        err = 1'b0;
        if ({1'b0, offset} >= SPAN) err = 1'b1;
        case (c_op)
            3'b000, 3'b100: begin end
            3'b001, 3'b101: if (c_addr[0]) err = 1'b1;
            3'b010:         if (c_addr[1:0] != 2'b00) err = 1'b1;
            default:        err = 1'b1;
        endcase
        if (c_wen && c_ren)  err = 1'b1;
        if (c_wen && c_op[2]) err = 1'b1;
        do_write = c_wen && !err;

        be         = '0;
        lane_wdata = '0;
        rdata      = '0;
        case (c_op[1:0])
            2'b00: begin
                be         = 4'b0001 << c_addr[1:0];
                lane_wdata = {4{c_wdata[7:0]}};
                rdata      = {{24{sel_b[7] & ~c_op[2]}}, sel_b};
            end
            2'b01: begin
                be         = c_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{c_wdata[15:0]}};
                rdata      = {{16{sel_h[15] & ~c_op[2]}}, sel_h};
            end
            2'b10: begin
                be         = 4'b1111;
                lane_wdata = c_wdata;
                rdata      = word;
            end
            default: begin end
        endcase
        if (err || !c_ren) rdata = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_addr   <= '0;
            lat_op     <= '0;
            lat_wen    <= 1'b0;
            lat_ren    <= 1'b0;
            lat_wdata  <= '0;
        end else begin
            if (accept) begin
                cnt       <= LAT;
                lat_addr  <= req_addr;
                lat_op    <= req_op;
                lat_wen   <= req_wen;
                lat_ren   <= req_ren;
                lat_wdata <= req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                resp_rdata <= rdata;
                resp_err   <= err;
            end
        end
    end

    // Array contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (rst && commit && do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= lane_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (LATENCY 2, 0, 4), a directed vector
// table, multi-cycle corner sequences and randomized traffic against a model.
`timescale 1ns/1ps
module tb_dmem_resp;
    localparam int ND = 3;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic                  clk = 1'b0;
    logic [ND-1:0]         rst;
    logic [ND-1:0]         req_valid, req_ready, req_wen, req_ren;
    logic [ND-1:0]         resp_valid, resp_ready, resp_err;
    logic [ND-1:0][31:0]   req_addr, req_wdata, resp_rdata;
    logic [ND-1:0][2:0]    req_op;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mm [ND][1024];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dmem_resp #(
            .ADDR_BITS(10),
            .BASE_ADDR(32'h8000_0000),
            .LATENCY((g == 0) ? 2 : (g == 1) ? 0 : 4)
        ) dut (
            .clk(clk), .rst(rst[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_addr(req_addr[g]), .req_op(req_op[g]),
            .req_wen(req_wen[g]), .req_ren(req_ren[g]), .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: access rules applied with plain arithmetic on a word array.
    task automatic model(input int d, input logic [31:0] a, input logic [2:0] op,
                         input logic w, input logic r, input logic [31:0] wd,
                         output logic [31:0] rd, output logic e);
        longint off;
        int     wi, sh, size;
        logic [31:0] wrd, v, mask;
        off = longint'(a) - longint'(BASE);
        e = 1'b0;
        rd = '0;
        if (off < 0 || off >= 4096) e = 1'b1;
        if (!(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1'b1;
        if ((op == 3'd1 || op == 3'd5) && a[0]) e = 1'b1;
        if (op == 3'd2 && a[1:0] != 2'b00) e = 1'b1;
        if (w && r) e = 1'b1;
        if (w && op >= 3'd4) e = 1'b1;
        if (e || (!w && !r)) return;
        wi   = int'(off / 4);
        sh   = 8 * int'(off % 4);
        size = (op == 3'd0 || op == 3'd4) ? 1 : (op == 3'd1 || op == 3'd5) ? 2 : 4;
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        wrd  = mm[d][wi];
        if (w) begin
            mm[d][wi] = (wrd & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            v = (wrd >> sh) & mask;
            if (op == 3'd0 && v >= 32'd128)   v = v - 32'd256;
            if (op == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            rd = v;
        end
    endtask

    // One full transaction; holds resp_ready low for 'hold' cycles after the response appears.
    task automatic txn(input int d, input logic [31:0] a, input logic [2:0] op,
                       input logic w, input logic r, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic e);
        int n;
        req_addr[d] = a; req_op[d] = op; req_wen[d] = w; req_ren[d] = r;
        req_wdata[d] = wd; req_valid[d] = 1'b1; resp_ready[d] = 1'b0;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d] = $urandom; req_op[d] = 3'($urandom); req_wdata[d] = $urandom;
        req_wen[d] = 1'($urandom); req_ren[d] = 1'($urandom);
        n = 0;
        while (resp_valid[d] !== 1'b1 && n < 100) begin
            chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
            @(negedge clk); n++;
        end
        chk("latency", 32'(n), 32'(lat_of(d)));
        rd = resp_rdata[d];
        e  = resp_err[d];
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid[d]), 32'd1);
            chk("bp_rdata", resp_rdata[d], rd);
            chk("bp_err", 32'(resp_err[d]), 32'(e));
            chk("bp_req_ready", 32'(req_ready[d]), 32'd0);
        end
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        chk("resp_drop", 32'(resp_valid[d]), 32'd0);
        chk("ready_back", 32'(req_ready[d]), 32'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  op;
        logic        wen;
        logic        ren;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd, mrd;
        logic        e, me;

        rst = '0; req_valid = '0; req_wen = '0; req_ren = '0; resp_ready = '0;
        req_addr = '0; req_wdata = '0; req_op = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_rdata", resp_rdata[d], 32'd0);
            chk("rst_err", 32'(resp_err[d]), 32'd0);
        end
        rst = '1;
        @(negedge clk);

        for (int d = 0; d < ND; d++) begin
            for (int wi = 0; wi < 16; wi++) begin
                logic [31:0] v;
                v = $urandom;
                txn(d, BASE + 32'(4 * wi), 3'b010, 1'b1, 1'b0, v, 0, rd, e);
                model(d, BASE + 32'(4 * wi), 3'b010, 1'b1, 1'b0, v, mrd, me);
                chk("preload_err", 32'(e), 32'd0);
            end
        end

        tbl.push_back('{32'h8000_0010, 3'b010, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 32'h0, 1'b0});
        tbl.push_back('{32'h8000_0010, 3'b010, 1'b0, 1'b1, 32'h0, 5, 32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{32'h8000_0013, 3'b000, 1'b0, 1'b1, 32'h0, 0, 32'hFFFF_FFDE, 1'b0});
        tbl.push_back('{32'h8000_0013, 3'b100, 1'b0, 1'b1, 32'h0, 0, 32'h0000_00DE, 1'b0});
        tbl.push_back('{32'h8000_0010, 3'b001, 1'b0, 1'b1, 32'h0, 0, 32'hFFFF_BEEF, 1'b0});
        tbl.push_back('{32'h8000_0012, 3'b101, 1'b0, 1'b1, 32'h0, 0, 32'h0000_DEAD, 1'b0});
        tbl.push_back('{32'h8000_0011, 3'b000, 1'b1, 1'b0, 32'h0000_0012, 0, 32'h0, 1'b0});
        tbl.push_back('{32'h8000_0010, 3'b010, 1'b0, 1'b1, 32'h0, 0, 32'hDEAD_12EF, 1'b0});
        tbl.push_back('{32'h8000_0002, 3'b010, 1'b0, 1'b1, 32'h0, 0, 32'h0, 1'b1});
        tbl.push_back('{32'h8000_0000, 3'b010, 1'b1, 1'b0, 32'h1122_3344, 0, 32'h0, 1'b0});
        tbl.push_back('{32'h7FFF_FFFC, 3'b010, 1'b1, 1'b0, 32'hCAFE_F00D, 0, 32'h0, 1'b1});
        tbl.push_back('{32'h8000_0000, 3'b010, 1'b0, 1'b1, 32'h0, 0, 32'h1122_3344, 1'b0});
        tbl.push_back('{32'h8000_0000, 3'b011, 1'b0, 1'b1, 32'h0, 0, 32'h0, 1'b1});
        tbl.push_back('{32'h8000_0002, 3'b001, 1'b1, 1'b0, 32'hABCD_1234, 0, 32'h0, 1'b0});
        tbl.push_back('{32'h8000_0000, 3'b010, 1'b0, 1'b1, 32'h0, 0, 32'h1234_3344, 1'b0});
        tbl.push_back('{32'h8000_0000, 3'b100, 1'b1, 1'b0, 32'hFF, 0, 32'h0, 1'b1});
        tbl.push_back('{32'h8000_0000, 3'b010, 1'b1, 1'b1, 32'h0, 0, 32'h0, 1'b1});
        tbl.push_back('{32'h8000_0000, 3'b010, 1'b0, 1'b0, 32'h5555_5555, 0, 32'h0, 1'b0});
        tbl.push_back('{32'h8000_0000, 3'b010, 1'b0, 1'b1, 32'h0, 0, 32'h1234_3344, 1'b0});
        tbl.push_back('{32'h8000_0FFC, 3'b010, 1'b1, 1'b0, 32'h0BAD_F00D, 0, 32'h0, 1'b0});
        tbl.push_back('{32'h8000_0FFC, 3'b010, 1'b0, 1'b1, 32'h0, 0, 32'h0BAD_F00D, 1'b0});
        tbl.push_back('{32'h8000_1000, 3'b010, 1'b0, 1'b1, 32'h0, 0, 32'h0, 1'b1});
        tbl.push_back('{32'h8000_0001, 3'b001, 1'b0, 1'b1, 32'h0, 0, 32'h0, 1'b1});
        tbl.push_back('{32'h8000_0001, 3'b000, 1'b0, 1'b1, 32'h0, 0, 32'h0000_0033, 1'b0});
        tbl.push_back('{32'h8000_0002, 3'b001, 1'b0, 1'b1, 32'h0, 0, 32'h0000_1234, 1'b0});

        foreach (tbl[i]) begin
            txn(0, tbl[i].addr, tbl[i].op, tbl[i].wen, tbl[i].ren, tbl[i].wdata, tbl[i].hold, rd, e);
            model(0, tbl[i].addr, tbl[i].op, tbl[i].wen, tbl[i].ren, tbl[i].wdata, mrd, me);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
        end

        // LATENCY=0 round trip with backpressure.
        txn(1, 32'h8000_0010, 3'b010, 1'b1, 1'b0, 32'h1357_9BDF, 0, rd, e);
        model(1, 32'h8000_0010, 3'b010, 1'b1, 1'b0, 32'h1357_9BDF, mrd, me);
        txn(1, 32'h8000_0010, 3'b010, 1'b0, 1'b1, 32'h0, 5, rd, e);
        chk("l0_load", rd, 32'h1357_9BDF);
        chk("l0_err", 32'(e), 32'd0);

        // Reset while the response is pending drops it.
        req_addr[1] = 32'h8000_0010; req_op[1] = 3'b010; req_wen[1] = 1'b0; req_ren[1] = 1'b1;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("rresp_valid_pre", 32'(resp_valid[1]), 32'd1);
        rst[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        chk("rresp_valid", 32'(resp_valid[1]), 32'd0);
        chk("rresp_rdata", resp_rdata[1], 32'd0);
        chk("rresp_ready", 32'(req_ready[1]), 32'd1);

        // Reset mid-WAIT at LATENCY=4 drops an uncommitted store.
        txn(2, 32'h8000_0020, 3'b010, 1'b1, 1'b0, 32'hA5A5_A5A5, 0, rd, e);
        model(2, 32'h8000_0020, 3'b010, 1'b1, 1'b0, 32'hA5A5_A5A5, mrd, me);
        txn(2, 32'h8000_0020, 3'b010, 1'b0, 1'b1, 32'h0, 0, rd, e);
        chk("rwait_preload", rd, 32'hA5A5_A5A5);
        req_addr[2] = 32'h8000_0020; req_op[2] = 3'b010; req_wen[2] = 1'b1; req_ren[2] = 1'b0;
        req_wdata[2] = 32'h0000_0055; req_valid[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b1;
        chk("rwait_valid", 32'(resp_valid[2]), 32'd0);
        chk("rwait_ready", 32'(req_ready[2]), 32'd1);
        chk("rwait_rdata", resp_rdata[2], 32'd0);
        chk("rwait_err", 32'(resp_err[2]), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("rwait_quiet", 32'(resp_valid[2]), 32'd0);
        end
        txn(2, 32'h8000_0020, 3'b010, 1'b0, 1'b1, 32'h0, 0, rd, e);
        chk("rwait_no_store", rd, 32'hA5A5_A5A5);

        for (int n = 0; n < 400; n++) begin
            int          d, sel, kind;
            logic [31:0] a, wd;
            logic [2:0]  op;
            logic        w, r;
            d   = $urandom_range(0, ND - 1);
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = BASE - 32'($urandom_range(1, 64));
            else if (sel == 1) a = BASE + 32'h1000 + 32'($urandom_range(0, 63));
            else               a = BASE + 32'($urandom_range(0, 63));
            op   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 5);
            w    = (kind <= 1) || (kind == 4);
            r    = (kind == 2) || (kind == 3) || (kind == 4);
            wd   = $urandom;
            txn(d, a, op, w, r, wd, $urandom_range(0, 2), rd, e);
            model(d, a, op, w, r, wd, mrd, me);
            chk("rnd_rdata", rd, mrd);
            chk("rnd_err", 32'(e), 32'(me));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
